// File: rtl/dma_copier.sv
// Word-granular memory-to-memory copy engine: MMIO register slave plus a bus master
// that alternates one read and one write per word, with an idle gap after each transaction.
module dma_copier #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LEN_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  s_a,
    input  logic [31:0] s_d,
    input  logic        s_we,
    output logic [31:0] s_spo,
    output logic [31:0] m_a,
    output logic [31:0] m_d,
    output logic        m_we,
    output logic        m_rd,
    input  logic [31:0] m_spo,
    input  logic        m_ready,
    input  logic        m_irq,
    output logic        irq
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_G1, S_WR, S_G2, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_src, r_dst, r_wsrc, r_wdst, r_buf;
    logic [LEN_W-1:0]  r_len, r_wlen;
    logic              r_done, r_err, r_ie;
    logic [WAIT_W-1:0] r_wait;
    logic              w_busy, w_ctrl_wr, w_start, w_abort, w_xfer, w_timeout;

    assign w_busy    = (r_state != S_IDLE);
    assign w_ctrl_wr = s_we && (s_a == 2'd3);
    assign w_start   = w_ctrl_wr && s_d[0] && !w_busy;
    assign w_timeout = (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign irq       = r_ie && (r_done || r_err);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        w_xfer  = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) w_next = (r_len == '0) ? S_DONE : S_RD;
            S_RD, S_WR: begin
                if (m_irq) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end else if (m_ready) begin
                    w_xfer = 1'b1;
                    w_next = (r_state == S_RD) ? S_G1 : S_G2;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_G1:    w_next = S_WR;
            S_G2:    w_next = (r_wlen == '0) ? S_DONE : S_RD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus outputs decode straight from state so an asynchronous reset drops requests at once.
    always_comb begin
        m_a  = '0;
        m_d  = '0;
        m_rd = 1'b0;
        m_we = 1'b0;
        case (r_state)
            S_RD: begin
                m_a  = r_wsrc;
                m_rd = 1'b1;
            end
            S_WR: begin
                m_a  = r_wdst;
                m_d  = r_buf;
                m_we = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_len  <= '0;
            r_wsrc <= '0;
            r_wdst <= '0;
            r_wlen <= '0;
            r_buf  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_ie   <= 1'b0;
            r_wait <= '0;
        end else begin
            if (s_we && !w_busy) begin
                case (s_a)
                    2'd0:    r_src <= {s_d[31:2], 2'b00};
                    2'd1:    r_dst <= {s_d[31:2], 2'b00};
                    2'd2:    r_len <= s_d[LEN_W-1:0];
                    default: ;
                endcase
            end
            if (w_ctrl_wr) r_ie <= s_d[3];

            // Internal set events take priority over a coincident software clear.
            if (r_state == S_DONE)          r_done <= 1'b1;
            else if (w_start)               r_done <= 1'b0;
            else if (w_ctrl_wr && s_d[1])   r_done <= 1'b0;

            if (w_abort)                    r_err <= 1'b1;
            else if (w_start)               r_err <= 1'b0;
            else if (w_ctrl_wr && s_d[2])   r_err <= 1'b0;

            if (w_start) begin
                r_wsrc <= r_src;
                r_wdst <= r_dst;
                r_wlen <= r_len;
            end
            if (w_xfer && (r_state == S_RD)) r_buf <= m_spo;
            if (w_xfer && (r_state == S_WR)) begin
                r_wsrc <= r_wsrc + 32'd4;
                r_wdst <= r_wdst + 32'd4;
                r_wlen <= r_wlen - 1'b1;
            end

            if (((r_state == S_RD) || (r_state == S_WR)) && !m_ready) r_wait <= r_wait + 1'b1;
            else                                                      r_wait <= '0;
        end
    end

    // Address and length registers show live working counters while a copy runs.
    always_comb begin
        s_spo = '0;
        case (s_a)
            2'd0: s_spo = w_busy ? r_wsrc : r_src;
            2'd1: s_spo = w_busy ? r_wdst : r_dst;
            2'd2: s_spo[LEN_W-1:0] = w_busy ? r_wlen : r_len;
            2'd3: s_spo[3:0] = {r_ie, r_err, r_done, w_busy};
            default: ;
        endcase
    end

endmodule
